// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the execute-stage control and mul_div_unit.
// master drives operands and MTHI/MTLO writes; slave returns busy/done and HI/LO.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit, one bit per cycle.
// Optional macro MUL_DIV_ABORT_EN adds an abort input that cancels an op in flight.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic reset,
`ifdef MUL_DIV_ABORT_EN
    input logic abort,
`endif
    mul_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] m;
    logic             sign_a;
    logic             sign_b;
    logic             is_div;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             abort_hit;
    logic             last;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_fits;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   quo_step;
    logic               neg_res;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

`ifdef MUL_DIV_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign last     = (count == CW'(WIDTH - 1));
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (abort_hit) state_next = IDLE;
                     else if (last) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // acc/quo double as product high/low (multiply) or remainder/dividend-quotient (divide)
    always_comb begin
        mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, m} : '0);
        div_trial = {acc, quo[WIDTH-1]};
        div_fits  = (div_trial >= {1'b0, m});
        if (is_div) begin
            acc_step = div_fits ? WIDTH'(div_trial - {1'b0, m}) : div_trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], div_fits};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            quo_step = {mul_sum[0], quo[WIDTH-1:1]};
        end
    end

    // Divide by zero leaves |a| in acc, so the normal remainder fixup restores a itself
    always_comb begin
        neg_res  = sign_a ^ sign_b;
        prod     = {acc, quo};
        prod_fix = neg_res ? -prod : prod;
        if (is_div) begin
            hi_fix = sign_a ? -acc : acc;
            lo_fix = (m == '0) ? '1 : (neg_res ? -quo : quo);
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        a_neg = bus.op[0] & bus.a[WIDTH-1];
        b_neg = bus.op[0] & bus.b[WIDTH-1];
        a_abs = a_neg ? -bus.a : bus.a;
        b_abs = b_neg ? -bus.b : bus.b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            quo    <= '0;
            m      <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        quo    <= a_abs;
                        m      <= b_abs;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        is_div <= bus.op[1];
                        count  <= '0;
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                RUN: begin
                    if (!abort_hit) begin
                        acc   <= acc_step;
                        quo   <= quo_step;
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    if (!abort_hit) begin
                        hi_r   <= hi_fix;
                        lo_r   <= lo_fix;
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
